jt12_slot_sched: RTL and testbench
==================================

# jt12_slot_sched

Slot sequencer and register-write scheduler for the JT12 24-slot operator pipeline. It generates the rotating slot index (channel/operator) that drives the per-slot shift-register chain, and queues CPU parameter writes, releasing each one only when its target slot reaches the insertion point of the pipeline. This keeps register updates coherent with the time-multiplexed datapath without stalling the CPU interface.

## Interface
- DW, 8: write data width.
- DEPTH, 4: pending-write FIFO depth; power of two, 2..16.
- LEAD, 0: slots of advance (0..23); a write fires LEAD slots before its target slot reaches index position.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  slot advance enable; one slot per clk_en cycle.
- wr_req  in  1  write request, sampled every clk (not gated by clk_en).
- wr_ch  in  3  target channel 0..5; 6, 7 invalid.
- wr_op  in  2  target operator 0..3 (S1..S4).
- wr_data  in  DW  value to write.
- wr_full  out  1  FIFO full; combinational from occupancy.
- wr_err  out  1  one-clk pulse: request dropped (invalid channel).
- cur_slot  out  5  current slot 0..23.
- cur_ch  out  3  current channel 0..5.
- cur_op  out  2  current operator.
- zero  out  1  high while cur_slot == 0.
- upd_en  out  1  one-clk write strobe.
- upd_slot  out  5  slot being written.
- upd_data  out  DW  data being written.

## Operation
- Slot order: group g = cur_slot/6 (0..3), cur_ch = cur_slot%6. Operator order per group is S1, S3, S2, S4: g0->op0, g1->op2, g2->op1, g3->op3.
- Slot counter: on clk_en, cur_slot wraps 23->0, otherwise increments. cur_ch/cur_op are kept as separate registered counters, always consistent with cur_slot.
- Target slot of a request: T = G(op)*6 + ch, where G is the inverse of the order map (op0->0, op2->1, op1->2, op3->3). Fire slot F = (T + 24 - LEAD) mod 24, computed at push time and stored with the data.
- Push: accepted on any clk with wr_req=1, wr_ch<=5 and wr_full=0. wr_req with wr_ch>5 is dropped and pulses wr_err on the next clk. wr_req while full is ignored without error; the requester must hold the request until wr_full=0.
- Pop: on a clk_en cycle, if the FIFO is non-empty and head F == cur_slot (value before advance), the next edge sets upd_en=1, upd_slot=T(head) and upd_data=head data, and pops the head. Only the head is eligible, so writes retire strictly in order, at most one per slot.
- Simultaneous push and pop: occupancy unchanged; a request pushed into an empty FIFO can fire no earlier than the next clk_en.
- Reset clears the FIFO, including in-flight entries, with no upd_en.

## Timing
- Reset values: cur_slot=0, cur_ch=0, cur_op=0, zero=1, upd_en=0, upd_slot=0, upd_data=0, wr_err=0, wr_full=0, FIFO empty.
- upd_en is a single-clk pulse regardless of clk_en spacing. upd_slot and upd_data hold until the next pulse.
- Worst-case write latency from acceptance: (k+1)*24 clk_en cycles, where k is the number of entries ahead.
- wr_full rises on the clk after the push that filled the FIFO and falls on the clk after a pop.
- With clk_en held at 1, the slot period is 24 clk.

## Test plan
- Reset, then clk_en=1 for 48 clk: cur_slot goes 0..23, 0..23; zero high at clk 0 and 24; slot 6 gives ch0/op2, slot 12 gives ch0/op1.
- LEAD=0, write ch2/op1 data 0x5A when cur_slot=3: T=14; a single upd_en pulse with upd_slot=14 and upd_data=0x5A on the edge after cur_slot=14.
- LEAD=2, write ch0/op0 0x11: fires while cur_slot=22 (wrap), upd_slot=0.
- Push 4 entries back-to-back (DEPTH=4): wr_full=1, a fifth wr_req is ignored; writes retire in order; wr_full drops after the first pop.
- wr_ch=6 gives a wr_err pulse with no FIFO change. With clk_en=0, slots and upd_en are frozen while pushes are still accepted.
- Assert rst mid-queue with 3 pending entries: no upd_en afterwards, cur_slot=0, FIFO empty.

Source files
------------

// File: rtl/jt12_slot_sched.sv
// ---------------------------------------------------------------------------
// jt12_slot_sched
//
// Slot sequencer and register-write scheduler for the JT12 24-slot operator
// pipeline. A rotating slot counter (with companion channel/operator
// counters) drives the per-slot shift-register chain. CPU parameter writes
// are queued in a small FIFO. Each write is released only when its target
// slot reaches the insertion point, which is LEAD slots ahead of the index
// position. This keeps register updates coherent with the time-multiplexed
// datapath without stalling the CPU side.
//
// Parameters
//   DW     write data width
//   DEPTH  pending-write FIFO depth (power of two, 2..16)
//   LEAD   slots of advance (0..23) between firing and the target slot
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   clk_en    slot advance enable (one slot per enabled clk)
//   wr_req    write request, sampled every clk
//   wr_ch     target channel 0..5 (6, 7 are rejected)
//   wr_op     target operator 0..3 (S1..S4)
//   wr_data   value to write
//   wr_full   FIFO full (combinational from occupancy)
//   wr_err    one-clk pulse when a request with an invalid channel is dropped
//   cur_slot  current slot 0..23
//   cur_ch    current channel 0..5
//   cur_op    current operator
//   zero      high while cur_slot == 0
//   upd_en    one-clk write strobe
//   upd_slot  slot being written (held between strobes)
//   upd_data  data being written (held between strobes)
// ---------------------------------------------------------------------------
module jt12_slot_sched #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int LEAD  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          wr_req,
    input  logic [2:0]    wr_ch,
    input  logic [1:0]    wr_op,
    input  logic [DW-1:0] wr_data,
    output logic          wr_full,
    output logic          wr_err,
    output logic [4:0]    cur_slot,
    output logic [2:0]    cur_ch,
    output logic [1:0]    cur_op,
    output logic          zero,
    output logic          upd_en,
    output logic [4:0]    upd_slot,
    output logic [DW-1:0] upd_data
);

    localparam int AW = $clog2(DEPTH);

    // -----------------------------------------------------------------------
    // Slot sequencer
    // -----------------------------------------------------------------------
    logic [4:0] slot_reg;
    logic [2:0] ch_reg;
    logic [1:0] grp_reg;
    logic [1:0] op_reg;
    logic [1:0] grp_next;

    assign grp_next = grp_reg + 2'd1;

    // Group-to-operator order S1,S3,S2,S4 (g0->op0, g1->op2, g2->op1,
    // g3->op3) is simply a swap of the two group bits; it is its own inverse,
    // so the same swap maps an operator back to its group.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg <= 5'd0;
            ch_reg   <= 3'd0;
            grp_reg  <= 2'd0;
            op_reg   <= 2'd0;
        end else if (clk_en) begin
            if (slot_reg == 5'd23) begin
                slot_reg <= 5'd0;
                ch_reg   <= 3'd0;
                grp_reg  <= 2'd0;
                op_reg   <= 2'd0;
            end else begin
                slot_reg <= slot_reg + 5'd1;
                if (ch_reg == 3'd5) begin
                    ch_reg  <= 3'd0;
                    grp_reg <= grp_next;
                    op_reg  <= {grp_next[0], grp_next[1]};
                end else begin
                    ch_reg <= ch_reg + 3'd1;
                end
            end
        end
    end

    assign cur_slot = slot_reg;
    assign cur_ch   = ch_reg;
    assign cur_op   = op_reg;
    assign zero     = (slot_reg == 5'd0);

    // -----------------------------------------------------------------------
    // Push-side slot arithmetic: target slot and fire slot
    // -----------------------------------------------------------------------
    logic [1:0] push_grp;
    logic [4:0] push_tgt;
    logic [5:0] fire_sum;
    logic [4:0] push_fire;

    always_comb begin
        push_grp  = {wr_op[0], wr_op[1]};
        push_tgt  = 5'(({3'd0, push_grp} * 5'd6) + {2'd0, wr_ch});
        // T + 24 - LEAD lies in 1..47, so a single conditional subtract
        // is enough to reduce it modulo 24.
        fire_sum  = {1'b0, push_tgt} + 6'd24 - 6'(LEAD);
        push_fire = (fire_sum >= 6'd24) ? 5'(fire_sum - 6'd24) : fire_sum[4:0];
    end

    // -----------------------------------------------------------------------
    // Pending-write FIFO
    // -----------------------------------------------------------------------
    logic [DW-1:0] mem_data [DEPTH];
    logic [4:0]    mem_tgt  [DEPTH];
    logic [4:0]    mem_fire [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic push_ok;
    logic pop_ok;
    logic ch_bad;

    assign wr_full = (count_reg == (AW+1)'(DEPTH));
    assign ch_bad  = (wr_ch > 3'd5);
    assign push_ok = wr_req && !ch_bad && !wr_full;
    // Only the head is eligible, and it is compared against the slot value
    // before this edge's advance. Frozen slots (clk_en=0) never retire.
    assign pop_ok  = clk_en && (count_reg != '0) && (mem_fire[rd_ptr_reg] == slot_reg);

    // Storage is not reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr_reg] <= wr_data;
            mem_tgt[wr_ptr_reg]  <= push_tgt;
            mem_fire[wr_ptr_reg] <= push_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registered strobes and update outputs
    // -----------------------------------------------------------------------
    logic          upd_en_reg;
    logic [4:0]    upd_slot_reg;
    logic [DW-1:0] upd_data_reg;
    logic          wr_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_en_reg   <= 1'b0;
            upd_slot_reg <= 5'd0;
            upd_data_reg <= '0;
            wr_err_reg   <= 1'b0;
        end else begin
            upd_en_reg <= pop_ok;
            wr_err_reg <= wr_req && ch_bad;
            if (pop_ok) begin
                upd_slot_reg <= mem_tgt[rd_ptr_reg];
                upd_data_reg <= mem_data[rd_ptr_reg];
            end
        end
    end

    assign upd_en   = upd_en_reg;
    assign upd_slot = upd_slot_reg;
    assign upd_data = upd_data_reg;
    assign wr_err   = wr_err_reg;

endmodule

// File: tb/tb_jt12_slot_sched.sv
// ---------------------------------------------------------------------------
// Testbench for jt12_slot_sched. Two instances share the stimulus: u0 with
// LEAD=0 and u2 with LEAD=2. A table of per-clk vectors covers the basic
// write, invalid-channel and frozen-slot behaviour; short hand-written
// sequences cover the slot walk, LEAD wrap, FIFO full and mid-queue reset.
// ---------------------------------------------------------------------------
module tb_jt12_slot_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       wr_req;
    logic [2:0] wr_ch;
    logic [1:0] wr_op;
    logic [7:0] wr_data;

    logic       u0_full, u0_err, u0_zero, u0_upd_en;
    logic [4:0] u0_slot, u0_upd_slot;
    logic [2:0] u0_ch;
    logic [1:0] u0_op;
    logic [7:0] u0_upd_data;

    logic       u2_full, u2_err, u2_zero, u2_upd_en;
    logic [4:0] u2_slot, u2_upd_slot;
    logic [2:0] u2_ch;
    logic [1:0] u2_op;
    logic [7:0] u2_upd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jt12_slot_sched #(.DW(8), .DEPTH(4), .LEAD(0)) u0 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .wr_req(wr_req), .wr_ch(wr_ch),
        .wr_op(wr_op), .wr_data(wr_data), .wr_full(u0_full), .wr_err(u0_err),
        .cur_slot(u0_slot), .cur_ch(u0_ch), .cur_op(u0_op), .zero(u0_zero),
        .upd_en(u0_upd_en), .upd_slot(u0_upd_slot), .upd_data(u0_upd_data)
    );

    jt12_slot_sched #(.DW(8), .DEPTH(4), .LEAD(2)) u2 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .wr_req(wr_req), .wr_ch(wr_ch),
        .wr_op(wr_op), .wr_data(wr_data), .wr_full(u2_full), .wr_err(u2_err),
        .cur_slot(u2_slot), .cur_ch(u2_ch), .cur_op(u2_op), .zero(u2_zero),
        .upd_en(u2_upd_en), .upd_slot(u2_upd_slot), .upd_data(u2_upd_data)
    );

    typedef struct {
        logic       en;
        logic       req;
        logic [2:0] ch;
        logic [1:0] op;
        logic [7:0] data;
        int         slot;
        int         upd;
        int         uslot;
        int         udata;
        int         full;
        int         err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic en, logic req, logic [2:0] ch, logic [1:0] op,
                                logic [7:0] data, int slot, int upd, int uslot,
                                int udata, int full, int err);
        vec_t v;
        v.en = en; v.req = req; v.ch = ch; v.op = op; v.data = data;
        v.slot = slot; v.upd = upd; v.uslot = uslot; v.udata = udata;
        v.full = full; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Advance one clk; inputs set before the call take effect at this edge
    // and outputs are read 1 time unit after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; clk_en = 1'b0; wr_req = 1'b0;
        wr_ch = 3'd0; wr_op = 2'd0; wr_data = 8'd0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic push(input logic [2:0] ch, input logic [1:0] op, input logic [7:0] d);
        wr_req = 1'b1; wr_ch = ch; wr_op = op; wr_data = d;
        tick;
        wr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int opmap[4];
        int seen;
        int exp_slot;
        opmap[0] = 0; opmap[1] = 2; opmap[2] = 1; opmap[3] = 3;

        // ---------------- reset values ----------------
        do_reset;
        chk("rst_slot", u0_slot, 0);
        chk("rst_ch", u0_ch, 0);
        chk("rst_op", u0_op, 0);
        chk("rst_zero", u0_zero, 1);
        chk("rst_upd_en", u0_upd_en, 0);
        chk("rst_upd_slot", u0_upd_slot, 0);
        chk("rst_upd_data", u0_upd_data, 0);
        chk("rst_err", u0_err, 0);
        chk("rst_full", u0_full, 0);
        chk("rst2_slot", u2_slot, 0);
        chk("rst2_upd_en", u2_upd_en, 0);
        $display("reset checked");

        // ---------------- slot walk, 48 clk ----------------
        clk_en = 1'b1;
        for (int i = 1; i <= 48; i++) begin
            tick;
            exp_slot = i % 24;
            chk($sformatf("walk%0d_slot", i), u0_slot, exp_slot);
            chk($sformatf("walk%0d_ch", i), u0_ch, exp_slot % 6);
            chk($sformatf("walk%0d_op", i), u0_op, opmap[exp_slot / 6]);
            chk($sformatf("walk%0d_zero", i), u0_zero, (exp_slot == 0) ? 1 : 0);
            $display("walk clk %0d slot %0d ch %0d op %0d zero %0d",
                     i, u0_slot, u0_ch, u0_op, u0_zero);
        end

        // ---------------- table-driven vectors (LEAD=0 instance) ----------------
        // Each row: inputs for one clk, then expected outputs after the edge.
        for (int s = 0; s < 3; s++)
            tbl.push_back(mk(1, 0, 0, 0, 8'h00, s + 1, 0, 0, 0, 0, 0));
        // ch2/op1 -> T = 2*6 + 2 = 14, pushed while cur_slot = 3
        tbl.push_back(mk(1, 1, 2, 1, 8'h5A, 4, 0, 0, 0, 0, 0));
        for (int s = 4; s < 14; s++)
            tbl.push_back(mk(1, 0, 0, 0, 8'h00, s + 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 15, 1, 14, 8'h5A, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 16, 0, 14, 8'h5A, 0, 0));
        // Frozen slots: invalid ch6 (would target slot 18 if stored), then a
        // valid push ch1/op0 -> T = 1 while the slot counter is held.
        tbl.push_back(mk(0, 1, 6, 1, 8'h77, 16, 0, 14, 8'h5A, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 16, 0, 14, 8'h5A, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'h33, 16, 0, 14, 8'h5A, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 16, 0, 14, 8'h5A, 0, 0));
        for (int s = 16; s < 24; s++)
            tbl.push_back(mk(1, 0, 0, 0, 8'h00, (s + 1) % 24, 0, 14, 8'h5A, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 14, 8'h5A, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 2, 1, 1, 8'h33, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 3, 0, 1, 8'h33, 0, 0));

        do_reset;
        foreach (tbl[r]) begin
            clk_en = tbl[r].en; wr_req = tbl[r].req; wr_ch = tbl[r].ch;
            wr_op = tbl[r].op; wr_data = tbl[r].data;
            tick;
            chk($sformatf("vec%0d_slot", r), u0_slot, tbl[r].slot);
            chk($sformatf("vec%0d_upd_en", r), u0_upd_en, tbl[r].upd);
            chk($sformatf("vec%0d_upd_slot", r), u0_upd_slot, tbl[r].uslot);
            chk($sformatf("vec%0d_upd_data", r), u0_upd_data, tbl[r].udata);
            chk($sformatf("vec%0d_full", r), u0_full, tbl[r].full);
            chk($sformatf("vec%0d_err", r), u0_err, tbl[r].err);
            $display("vec %0d en %0d req %0d ch %0d slot %0d upd %0d/%0d/%02h err %0d",
                     r, tbl[r].en, tbl[r].req, tbl[r].ch, u0_slot, u0_upd_en,
                     u0_upd_slot, u0_upd_data, u0_err);
        end
        wr_req = 1'b0;

        // ---------------- LEAD=2: ch0/op0 fires at slot 22 ----------------
        do_reset;
        clk_en = 1'b1;
        push(3'd0, 2'd0, 8'h11);          // pushed at slot 0, now slot 1
        seen = 0;
        for (int i = 0; i < 21; i++) begin
            tick;
            if (u2_upd_en) seen++;
        end
        chk("lead2_early_upd", seen, 0);
        chk("lead2_pre_slot", u2_slot, 22);
        tick;
        chk("lead2_upd_en", u2_upd_en, 1);
        chk("lead2_upd_slot", u2_upd_slot, 0);
        chk("lead2_upd_data", u2_upd_data, 8'h11);
        chk("lead2_slot", u2_slot, 23);
        tick;
        chk("lead2_pulse_end", u2_upd_en, 0);
        chk("lead2_hold_data", u2_upd_data, 8'h11);
        $display("lead2 write slot %0d data %02h", u2_upd_slot, u2_upd_data);

        // ---------------- FIFO full and in-order retirement ----------------
        do_reset;
        clk_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(3'(k), 2'd0, 8'(8'hA0 + k));
            chk($sformatf("fill%0d_full", k), u0_full, (k == 3) ? 1 : 0);
            $display("fill %0d full %0d", k, u0_full);
        end
        push(3'd4, 2'd0, 8'hA4);          // ignored while full, no error
        chk("fifth_full", u0_full, 1);
        chk("fifth_err", u0_err, 0);
        clk_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("retire%0d_en", k), u0_upd_en, 1);
            chk($sformatf("retire%0d_slot", k), u0_upd_slot, k);
            chk($sformatf("retire%0d_data", k), u0_upd_data, 8'hA0 + k);
            chk($sformatf("retire%0d_full", k), u0_full, 0);
            $display("retire %0d slot %0d data %02h", k, u0_upd_slot, u0_upd_data);
        end
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            tick;
            if (u0_upd_en) seen++;
        end
        chk("fifth_never_fires", seen, 0);

        // ---------------- reset mid-queue ----------------
        do_reset;
        clk_en = 1'b1;
        push(3'd2, 2'd3, 8'hC0);          // T = 20
        push(3'd3, 2'd3, 8'hC1);          // T = 21
        push(3'd4, 2'd3, 8'hC2);          // T = 22
        for (int i = 0; i < 7; i++) tick;
        chk("midq_pre_slot", u0_slot, 10);
        rst = 1'b1;
        tick;
        chk("midq_slot", u0_slot, 0);
        chk("midq_ch", u0_ch, 0);
        chk("midq_op", u0_op, 0);
        chk("midq_upd_en", u0_upd_en, 0);
        chk("midq_full", u0_full, 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 48; i++) begin
            tick;
            if (u0_upd_en || u2_upd_en) seen++;
        end
        chk("midq_no_upd", seen, 0);
        clk_en = 1'b0;
        push(3'd0, 2'd0, 8'h01);          // one entry must not fill a cleared FIFO
        chk("midq_empty_full", u0_full, 0);
        $display("midq reset slot %0d upd_seen %0d", u0_slot, seen);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
